seq_step_ctrl: RTL

SEQ_STEP_CTRL -- requirements
Module: seq_step_ctrl

---
 rtl/seq_step_if.sv | 34 +++
 rtl/seq_step_ctrl.sv | 82 ++++++++
 2 files changed

// File: rtl/seq_step_if.sv
// Handshake/config bundle for seq_step_ctrl. The dir signal exists only when
// SEQ_REVERSE_EN is defined.
interface seq_step_if #(
  parameter int WIDTH       = 3,
  parameter int MAX_STEPS_W = 8
);
  logic                   start;
  logic                   stop;
  logic                   hold;
  logic [MAX_STEPS_W-1:0] num_steps;
  logic                   cfg_we;
  logic [1:0]             cfg_addr;
  logic [WIDTH-1:0]       cfg_data;
`ifdef SEQ_REVERSE_EN
  logic                   dir;
`endif
  logic [WIDTH-1:0]       count;
  logic [1:0]             step_idx;
  logic                   busy;
  logic                   done;
  logic [MAX_STEPS_W-1:0] steps_left;

`ifdef SEQ_REVERSE_EN
  modport master (output start, stop, hold, num_steps, cfg_we, cfg_addr, cfg_data, dir,
                  input  count, step_idx, busy, done, steps_left);
  modport slave  (input  start, stop, hold, num_steps, cfg_we, cfg_addr, cfg_data, dir,
                  output count, step_idx, busy, done, steps_left);
`else
  modport master (output start, stop, hold, num_steps, cfg_we, cfg_addr, cfg_data,
                  input  count, step_idx, busy, done, steps_left);
  modport slave  (input  start, stop, hold, num_steps, cfg_we, cfg_addr, cfg_data,
                  output count, step_idx, busy, done, steps_left);
`endif
endinterface

// File: rtl/seq_step_ctrl.sv
// Steps through a 4-entry programmable value table, bounded or free-running.
// Optional SEQ_REVERSE_EN adds a dir input for downward stepping.
module seq_step_ctrl #(
  parameter int WIDTH       = 3,
  parameter int MAX_STEPS_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_step_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_n;
  logic [3:0][WIDTH-1:0]   tbl;
  logic [WIDTH-1:0]        count, cnt_n;
  logic [1:0]              step_idx, idx_n, idx_adv;
  logic [MAX_STEPS_W-1:0]  steps_left, left_n;

`ifdef SEQ_REVERSE_EN
  assign idx_adv = bus.dir ? step_idx - 2'd1 : step_idx + 2'd1;
`else
  assign idx_adv = step_idx + 2'd1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      step_idx   <= '0;
      steps_left <= '0;
      tbl[0]     <= '0;
      tbl[1]     <= WIDTH'(2);
      tbl[2]     <= WIDTH'(3);
      tbl[3]     <= WIDTH'(7);
    end else begin
      state      <= state_n;
      count      <= cnt_n;
      step_idx   <= idx_n;
      steps_left <= left_n;
      // count sees the pre-write table on a same-cycle start
      if (state == IDLE && bus.cfg_we) tbl[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = count;
    idx_n   = step_idx;
    left_n  = steps_left;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_n = RUN;
          idx_n   = 2'd0;
          cnt_n   = tbl[0];
          left_n  = bus.num_steps;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_n = IDLE;
        end else if (!bus.hold) begin
          idx_n = idx_adv;
          cnt_n = tbl[idx_adv];
          // steps_left==0 while running can only mean a free run
          if (steps_left != '0) begin
            left_n = steps_left - 1'b1;
            if (steps_left == MAX_STEPS_W'(1)) state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.count      = count;
  assign bus.step_idx   = step_idx;
  assign bus.steps_left = steps_left;
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
endmodule
